// File: rtl/pdm_audio_tx.sv
// pdm_audio_tx
//   PCM-to-PDM transmitter for the board audio output. Signed PCM samples
//   arrive on a valid/ready stream and are held in a 2-entry FIFO. A
//   first-order sigma-delta modulator turns the current sample into a PDM
//   bitstream with one bit every CLK_DIV clocks. Each sample is played for
//   OVERSAMPLE PDM bits, and that span is one frame.
//
//   Optional feature (macro PDM_TX_HOLD_LAST_EN):
//     defined   -> on underrun the last sample keeps playing
//     undefined -> on underrun the output falls back to midscale (signed 0)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-low
//   enable     in   1 = run; 0 = idle, flush FIFO, outputs low
//   s_valid    in   sample valid
//   s_ready    out  sample accepted when s_valid & s_ready (combinational)
//   s_data     in   signed PCM sample, SAMPLE_W bits
//   audio_pdm  out  PDM bitstream, registered
//   audio_on   out  amplifier enable, registered copy of enable
//   pdm_tick   out  1-cycle pulse on the cycle audio_pdm takes a new bit
//   underrun   out  1-cycle pulse: frame boundary found the FIFO empty
//
// Handshake: a sample transfers on every rising clk edge where s_valid and
// s_ready are both high. s_ready does not depend on s_valid. While s_ready
// is low, s_valid/s_data are ignored.
module pdm_audio_tx #(
  parameter int CLK_DIV    = 16,
  parameter int OVERSAMPLE = 64,
  parameter int SAMPLE_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                audio_pdm,
  output logic                audio_on,
  output logic                pdm_tick,
  output logic                underrun
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int SLOT_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(OVERSAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] SIGN_BIT  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SAMPLE_W-1:0] fifo_q [2];
  logic [SAMPLE_W-1:0] fifo_d [2];
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  // cur holds the signed sample; signed 0 is midscale in offset binary.
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic                audio_pdm_q, audio_pdm_d;
  logic                audio_on_q, audio_on_d;
  logic                pdm_tick_q, pdm_tick_d;
  logic                underrun_q, underrun_d;

  logic                tick, frame, fifo_empty, push, pop;
  logic [SAMPLE_W-1:0] cur_sel, u;
  logic [SAMPLE_W:0]   sum;

  always_comb begin
    tick       = enable && (div_cnt_q == DIV_LAST);
    frame      = tick && (slot_q == '0);
    fifo_empty = (fifo_cnt_q == 2'd0);
    s_ready    = enable && (fifo_cnt_q != 2'd2);
    push       = s_valid && s_ready;
    // No bypass: a push in the same cycle as an empty-FIFO boundary
    // cannot be popped, so that boundary still underruns.
    pop        = frame && !fifo_empty;

    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    slot_d    = slot_q;
    if (tick) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

    // The sample selected at a frame boundary drives that boundary's bit.
    cur_sel = cur_q;
    if (frame) begin
      if (!fifo_empty) begin
        cur_sel = fifo_q[0];
      end else begin
`ifdef PDM_TX_HOLD_LAST_EN
        cur_sel = cur_q;
`else
        cur_sel = '0;
`endif
      end
    end

    // First-order sigma-delta: carry out of acc + u is the output bit,
    // and dropping the carry subtracts 2^W from the accumulator.
    u           = cur_sel ^ SIGN_BIT;
    sum         = {1'b0, acc_q} + {1'b0, u};
    acc_d       = acc_q;
    audio_pdm_d = audio_pdm_q;
    if (tick) begin
      acc_d       = sum[SAMPLE_W-1:0];
      audio_pdm_d = sum[SAMPLE_W];
    end
    cur_d = cur_sel;

    // Entry 0 is the head. Push+pop can only happen with exactly one
    // entry stored, so the new sample simply replaces the head.
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10: begin
        fifo_d[fifo_cnt_q[0]] = s_data;
        fifo_cnt_d            = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0]  = fifo_q[1];
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: fifo_d[0] = s_data;
      default: ;
    endcase

    pdm_tick_d = tick;
    underrun_d = frame && fifo_empty;
    audio_on_d = enable;

    // Disable returns everything to its reset state on the next edge.
    if (!enable) begin
      div_cnt_d   = '0;
      slot_d      = '0;
      fifo_cnt_d  = 2'd0;
      acc_d       = '0;
      cur_d       = '0;
      audio_pdm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      slot_q      <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_cnt_q  <= 2'd0;
      acc_q       <= '0;
      cur_q       <= '0;
      audio_pdm_q <= 1'b0;
      audio_on_q  <= 1'b0;
      pdm_tick_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      slot_q      <= slot_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      fifo_cnt_q  <= fifo_cnt_d;
      acc_q       <= acc_d;
      cur_q       <= cur_d;
      audio_pdm_q <= audio_pdm_d;
      audio_on_q  <= audio_on_d;
      pdm_tick_q  <= pdm_tick_d;
      underrun_q  <= underrun_d;
    end
  end

  assign audio_pdm = audio_pdm_q;
  assign audio_on  = audio_on_q;
  assign pdm_tick  = pdm_tick_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Testbench for pdm_audio_tx with CLK_DIV=4, OVERSAMPLE=8, SAMPLE_W=16.
// Expected {underrun, audio_pdm} pairs are queued when a sample is accepted
// (or when an underrun frame is anticipated) and popped on every pdm_tick.
module tb_pdm_audio_tx;

  localparam int CLK_DIV    = 4;
  localparam int OVERSAMPLE = 8;
  localparam int SAMPLE_W   = 16;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                audio_pdm;
  logic                audio_on;
  logic                pdm_tick;
  logic                underrun;

  int tests = 0;
  int fails = 0;

  logic [1:0]          exp_q [$];
  logic [SAMPLE_W-1:0] feed_q [$];
  logic [SAMPLE_W-1:0] tb_acc;
  int                  first_tick_cyc;

  pdm_audio_tx #(
    .CLK_DIV   (CLK_DIV),
    .OVERSAMPLE(OVERSAMPLE),
    .SAMPLE_W  (SAMPLE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .audio_pdm(audio_pdm),
    .audio_on (audio_on),
    .pdm_tick (pdm_tick),
    .underrun (underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference sigma-delta: queue one frame of expected bits for sample smp.
  // ur marks the frame as starting with an underrun pulse.
  task automatic push_frame(input logic [SAMPLE_W-1:0] smp, input bit ur);
    logic [SAMPLE_W:0]   s;
    logic [SAMPLE_W-1:0] off;
    off = smp ^ 16'h8000;
    for (int i = 0; i < OVERSAMPLE; i++) begin
      s = {1'b0, tb_acc} + {1'b0, off};
      exp_q.push_back({ur && (i == 0), s[SAMPLE_W]});
      tb_acc = s[SAMPLE_W-1:0];
    end
  endtask

  // Driver + monitor: entered and left at a negedge. Feeds feed_q on the
  // stream and compares each tick against the scoreboard until n ticks seen.
  task automatic run_ticks(input int n);
    int          seen;
    int          cyc;
    int          limit;
    bit          fire;
    logic [1:0]  ent;
    seen  = 0;
    cyc   = 0;
    limit = n * CLK_DIV + 40;
    first_tick_cyc = -1;
    while (seen < n && cyc < limit) begin
      if (pdm_tick) begin
        if (seen == 0) first_tick_cyc = cyc;
        seen++;
        ent = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        check("tick_bits", {30'd0, underrun, audio_pdm}, {30'd0, ent});
      end else begin
        check("underrun_off_tick", {31'd0, underrun}, 32'd0);
      end
      s_valid = (feed_q.size() != 0);
      s_data  = (feed_q.size() != 0) ? feed_q[0] : '0;
      #1;
      fire = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (fire) push_frame(feed_q.pop_front(), 1'b0);
    end
    s_valid = 1'b0;
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  logic [SAMPLE_W-1:0] ur_smp;

  // ---------------- directed sequence ----------------
  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    tb_acc  = '0;
    repeat (3) @(negedge clk);
    check("rst_audio_pdm", {31'd0, audio_pdm}, 32'd0);
    check("rst_audio_on",  {31'd0, audio_on},  32'd0);
    check("rst_s_ready",   {31'd0, s_ready},   32'd0);
    check("rst_pdm_tick",  {31'd0, pdm_tick},  32'd0);
    check("rst_underrun",  {31'd0, underrun},  32'd0);

    // Idle with enable low: no ticks, nothing accepted.
    reset = 1'b1;
    begin
      int ticks_idle;
      ticks_idle = 0;
      s_valid = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (pdm_tick) ticks_idle++;
      end
      check("idle_ticks", ticks_idle, 0);
      check("idle_s_ready", {31'd0, s_ready}, 32'd0);
      check("idle_audio_on", {31'd0, audio_on}, 32'd0);
      s_valid = 1'b0;
    end

    // Backpressure, then continuous midscale: 0,1,0,1 with no underrun.
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0000;
    tb_acc  = '0;
    #1 check("bp_ready_c1", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    push_frame(16'h0000, 1'b0);
    check("audio_on_rise", {31'd0, audio_on}, 32'd1);
    check("bp_ready_c2", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    push_frame(16'h0000, 1'b0);
    check("bp_ready_c3_full", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    check("no_tick_before_div", {31'd0, pdm_tick}, 32'd0);
    @(negedge clk);
    check("bp_ready_after_pop", {31'd0, s_ready}, 32'd1);
    feed_q = '{16'h0000, 16'h0000, 16'h0000};
    run_ticks(5 * OVERSAMPLE);
    check("mid_exp_drained", exp_q.size(), 0);
    enable = 1'b0;
    @(negedge clk);
    check("dis_audio_on", {31'd0, audio_on}, 32'd0);
    check("dis_audio_pdm", {31'd0, audio_pdm}, 32'd0);
    repeat (3) @(negedge clk);

    // Density (3/4 ones, then all zeros), then underrun frames.
    enable = 1'b1;
    tb_acc = '0;
    feed_q = '{16'h4000, 16'h4000, 16'h8000, 16'h4000};
    run_ticks(4 * OVERSAMPLE);
    check("first_tick_lat_b", first_tick_cyc, CLK_DIV);
`ifdef PDM_TX_HOLD_LAST_EN
    ur_smp = 16'h4000;
`else
    ur_smp = 16'h0000;
`endif
    push_frame(ur_smp, 1'b1);
    push_frame(ur_smp, 1'b1);
    run_ticks(2 * OVERSAMPLE);
    check("ur_exp_drained", exp_q.size(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Mid-frame disable with a sample still queued, then re-enable.
    enable = 1'b1;
    tb_acc = '0;
    feed_q = '{16'h4000, 16'h4000, 16'h4000};
    run_ticks(OVERSAMPLE + 4);
    check("pre_dis_pdm", {31'd0, audio_pdm}, 32'd1);
    enable = 1'b0;
    feed_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("mdis_audio_pdm", {31'd0, audio_pdm}, 32'd0);
    check("mdis_audio_on", {31'd0, audio_on}, 32'd0);
    check("mdis_pdm_tick", {31'd0, pdm_tick}, 32'd0);
    check("mdis_s_ready", {31'd0, s_ready}, 32'd0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    tb_acc = '0;
    feed_q = '{16'h0000, 16'h0000};
    run_ticks(2 * OVERSAMPLE);
    check("first_tick_lat_c", first_tick_cyc, CLK_DIV);
    check("re_exp_drained", exp_q.size(), 0);
    enable = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed time limit expected finish");
    $fatal(1, "time limit");
  end

endmodule
